// File: rtl/load_unit_if.sv
// Pipeline-side load handshake plus data-memory read port for the load unit.
// slave = the load unit itself, master = pipeline/memory environment.
interface load_unit_if;
  logic        ld_req;
  logic [15:0] ld_addr;
  logic        ld_byte;
  logic        ld_signed;
  logic        flush;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        ld_done;
  logic [15:0] ld_data;
  logic        ld_err;

  modport slave (
    input  ld_req, ld_addr, ld_byte, ld_signed, flush, mem_gnt, mem_rvalid, mem_rdata,
    output mem_rd_req, mem_addr, stall, ld_done, ld_data, ld_err
  );

  modport master (
    output ld_req, ld_addr, ld_byte, ld_signed, flush, mem_gnt, mem_rvalid, mem_rdata,
    input  mem_rd_req, mem_addr, stall, ld_done, ld_data, ld_err
  );
endinterface

// File: rtl/load_unit.sv
// MEM-stage load unit: halfword/byte loads over a gnt/rvalid memory port,
// with misalignment and timeout errors and flush-abandon (DRAIN) handling.
module load_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      rst_n,
  load_unit_if.slave lu
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR, DRAIN} state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_addr, r_data;
  logic        r_lo, r_byte, r_signed;
  logic        w_accept, w_capture, w_clear;
  logic [7:0]  w_lane;
  logic [15:0] w_fmt;

  // Big-endian: even byte address lives in the upper half of the halfword.
  always_comb begin
    w_lane = r_lo ? lu.mem_rdata[7:0] : lu.mem_rdata[15:8];
    w_fmt  = r_byte ? {{8{r_signed & w_lane[7]}}, w_lane} : lu.mem_rdata;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!lu.flush && lu.ld_req) begin
          if (!lu.ld_byte && lu.ld_addr[0]) begin
            w_state_nxt = ERR;
            w_clear     = 1'b1;
          end else begin
            w_state_nxt = REQ;
            w_accept    = 1'b1;
          end
        end
      end
      REQ: begin
        if (lu.mem_gnt) begin
          w_cnt_nxt   = '0;
          w_state_nxt = lu.flush ? DRAIN : WAIT;
        end else if (lu.flush) begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (lu.mem_rvalid) begin
          w_state_nxt = lu.flush ? IDLE : DONE;
          w_capture   = !lu.flush;
        end else if (lu.flush) begin
          // Keep the post-grant budget running so DRAIN cannot outlive it.
          w_state_nxt = DRAIN;
          if (r_cnt < CNT_LAST) w_cnt_nxt = r_cnt + 4'd1;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = ERR;
          w_clear     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      DRAIN: begin
        if (lu.mem_rvalid || r_cnt >= CNT_LAST) w_state_nxt = IDLE;
        else                                    w_cnt_nxt   = r_cnt + 4'd1;
      end
      DONE:    w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_lo     <= 1'b0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr   <= {lu.ld_addr[15:1], 1'b0};
        r_lo     <= lu.ld_addr[0];
        r_byte   <= lu.ld_byte;
        r_signed <= lu.ld_signed;
      end
      if (w_capture)    r_data <= w_fmt;
      else if (w_clear) r_data <= '0;
    end
  end

  assign lu.mem_rd_req = (r_state == REQ);
  assign lu.mem_addr   = r_addr;
  assign lu.ld_done    = (r_state == DONE);
  assign lu.ld_err     = (r_state == ERR);
  assign lu.ld_data    = r_data;
  assign lu.stall      = (r_state == REQ) || (r_state == WAIT) ||
                         (((r_state == IDLE) || (r_state == DRAIN)) && lu.ld_req);

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: table of single loads plus hand sequences
// for timeout, flush/drain, and reset-during-load.
module tb_load_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  load_unit_if lu();

  load_unit #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lu    (lu)
  );

  typedef struct {
    logic [15:0] addr;
    logic        byt;
    logic        sgn;
    logic [15:0] rdata;
    logic        err;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One load with immediate grant and rvalid in the first WAIT cycle.
  task automatic run_vec(input vec_t v);
    lu.ld_req = 1'b1; lu.ld_addr = v.addr; lu.ld_byte = v.byt; lu.ld_signed = v.sgn;
    #2; chk1("idle_stall", lu.stall, 1'b1); chk1("idle_rdreq", lu.mem_rd_req, 1'b0);
    tick();
    if (v.err) begin
      #2;
      chk1("err_pulse", lu.ld_err, 1'b1);
      chk16("err_data", lu.ld_data, 16'h0000);
      chk1("err_rdreq", lu.mem_rd_req, 1'b0);
      chk1("err_stall", lu.stall, 1'b0);
      tick();
    end else begin
      lu.mem_gnt = 1'b1;
      #2; chk1("req_rdreq", lu.mem_rd_req, 1'b1); chk16("req_addr", lu.mem_addr, v.exp_addr);
      chk1("req_stall", lu.stall, 1'b1);
      tick(); lu.mem_gnt = 1'b0;
      lu.mem_rvalid = 1'b1; lu.mem_rdata = v.rdata;
      #2; chk1("wait_rdreq", lu.mem_rd_req, 1'b0); chk1("wait_stall", lu.stall, 1'b1);
      chk1("wait_done", lu.ld_done, 1'b0);
      tick(); lu.mem_rvalid = 1'b0; lu.mem_rdata = 16'h0000;
      #2; chk1("done_pulse", lu.ld_done, 1'b1); chk16("done_data", lu.ld_data, v.exp_data);
      chk1("done_stall", lu.stall, 1'b0);
      tick();
    end
    lu.ld_req = 1'b0;
    #2; chk1("after_done", lu.ld_done, 1'b0); chk1("after_err", lu.ld_err, 1'b0);
    chk16("hold_data", lu.ld_data, v.err ? 16'h0000 : v.exp_data);
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    lu.ld_req = 1'b0; lu.ld_addr = 16'h0000; lu.ld_byte = 1'b0; lu.ld_signed = 1'b0;
    lu.flush = 1'b0; lu.mem_gnt = 1'b0; lu.mem_rvalid = 1'b0; lu.mem_rdata = 16'h0000;
    #1 rst_n = 1'b0;

    //        addr      byt   sgn   rdata     err   exp_addr  exp_data
    vt[0]  = '{16'h0010, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'h0010, 16'hBEEF};
    vt[1]  = '{16'h0003, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    vt[2]  = '{16'h0021, 1'b1, 1'b1, 16'h1280, 1'b0, 16'h0020, 16'hFF80};
    vt[3]  = '{16'h0021, 1'b1, 1'b0, 16'h1280, 1'b0, 16'h0020, 16'h0080};
    vt[4]  = '{16'h0020, 1'b1, 1'b0, 16'h1280, 1'b0, 16'h0020, 16'h0012};
    vt[5]  = '{16'h0020, 1'b1, 1'b1, 16'h8534, 1'b0, 16'h0020, 16'hFF85};
    vt[6]  = '{16'h0003, 1'b1, 1'b1, 16'h00F0, 1'b0, 16'h0002, 16'hFFF0};
    vt[7]  = '{16'h1234, 1'b0, 1'b1, 16'h80FF, 1'b0, 16'h1234, 16'h80FF};
    vt[8]  = '{16'hFFFF, 1'b1, 1'b0, 16'hAB7F, 1'b0, 16'hFFFE, 16'h007F};
    vt[9]  = '{16'hFFFE, 1'b1, 1'b1, 16'h7F80, 1'b0, 16'hFFFE, 16'h007F};
    vt[10] = '{16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    vt[11] = '{16'hFFFE, 1'b0, 1'b0, 16'h7FFF, 1'b0, 16'hFFFE, 16'h7FFF};

    // Reset state; stall follows ld_req even in reset.
    repeat (2) @(posedge clk);
    #3;
    chk1("rst_rdreq", lu.mem_rd_req, 1'b0); chk16("rst_addr", lu.mem_addr, 16'h0000);
    chk1("rst_done", lu.ld_done, 1'b0); chk1("rst_err", lu.ld_err, 1'b0);
    chk16("rst_data", lu.ld_data, 16'h0000); chk1("rst_stall0", lu.stall, 1'b0);
    lu.ld_req = 1'b1;
    #1; chk1("rst_stall1", lu.stall, 1'b1);
    lu.ld_req = 1'b0;
    tick(); rst_n = 1'b1; tick();

    for (int i = 0; i < NV; i++) run_vec(vt[i]);

    // Timeout: grant, then 15 WAIT cycles without rvalid.
    lu.ld_req = 1'b1; lu.ld_byte = 1'b0; lu.ld_addr = 16'h0040; tick();
    lu.mem_gnt = 1'b1; #2; chk1("to_rdreq", lu.mem_rd_req, 1'b1); tick(); lu.mem_gnt = 1'b0;
    for (int c = 0; c < 15; c++) begin
      #2; chk1("to_wait_stall", lu.stall, 1'b1); chk1("to_wait_noerr", lu.ld_err, 1'b0);
      tick();
    end
    #2; chk1("to_err", lu.ld_err, 1'b1); chk16("to_err_data", lu.ld_data, 16'h0000);
    chk1("to_err_stall", lu.stall, 1'b0);
    tick();
    lu.ld_req = 1'b0; lu.mem_rvalid = 1'b1; lu.mem_rdata = 16'h5555;
    #2; chk1("to_idle_err", lu.ld_err, 1'b0); chk1("to_idle_stall", lu.stall, 1'b0);
    tick(); lu.mem_rvalid = 1'b0;
    #2; chk1("to_late_rvalid", lu.ld_done, 1'b0); chk16("to_late_data", lu.ld_data, 16'h0000);
    tick();

    run_vec(vt[0]);

    // Flush in WAIT, new ld_req during DRAIN, rvalid two cycles after flush.
    lu.ld_req = 1'b1; lu.ld_addr = 16'h0050; lu.ld_byte = 1'b0; tick();
    lu.mem_gnt = 1'b1; tick(); lu.mem_gnt = 1'b0;
    lu.flush = 1'b1; #2; chk1("fw_stall", lu.stall, 1'b1); tick(); lu.flush = 1'b0;
    lu.ld_addr = 16'h0060;
    #2; chk1("dr_stall1", lu.stall, 1'b1); chk1("dr_rdreq1", lu.mem_rd_req, 1'b0);
    chk1("dr_done1", lu.ld_done, 1'b0);
    tick();
    lu.mem_rvalid = 1'b1; lu.mem_rdata = 16'h1111;
    #2; chk1("dr_stall2", lu.stall, 1'b1); chk1("dr_done2", lu.ld_done, 1'b0);
    chk1("dr_rdreq2", lu.mem_rd_req, 1'b0);
    tick(); lu.mem_rvalid = 1'b0;
    #2; chk1("dr_idle_stall", lu.stall, 1'b1); chk1("dr_idle_done", lu.ld_done, 1'b0);
    chk16("dr_hold_data", lu.ld_data, 16'hBEEF); chk1("dr_idle_rdreq", lu.mem_rd_req, 1'b0);
    tick();
    #2; chk1("new_rdreq", lu.mem_rd_req, 1'b1); chk16("new_addr", lu.mem_addr, 16'h0060);
    lu.mem_gnt = 1'b1; tick(); lu.mem_gnt = 1'b0;
    lu.mem_rvalid = 1'b1; lu.mem_rdata = 16'h2222; tick(); lu.mem_rvalid = 1'b0;
    #2; chk1("new_done", lu.ld_done, 1'b1); chk16("new_data", lu.ld_data, 16'h2222);
    tick(); lu.ld_req = 1'b0; tick();

    // Delayed grant (rvalid in REQ ignored), then flush coincident with rvalid.
    lu.ld_req = 1'b1; lu.ld_addr = 16'h0080; tick();
    lu.mem_rvalid = 1'b1; lu.mem_rdata = 16'h9999;
    #2; chk1("dg_rdreq1", lu.mem_rd_req, 1'b1); chk16("dg_addr", lu.mem_addr, 16'h0080);
    tick(); lu.mem_rvalid = 1'b0;
    #2; chk1("dg_rdreq2", lu.mem_rd_req, 1'b1); chk1("dg_nodone", lu.ld_done, 1'b0);
    lu.mem_gnt = 1'b1; tick(); lu.mem_gnt = 1'b0;
    lu.mem_rvalid = 1'b1; lu.mem_rdata = 16'h3333; lu.flush = 1'b1;
    #2; chk1("fr_stall", lu.stall, 1'b1);
    tick(); lu.mem_rvalid = 1'b0; lu.flush = 1'b0; lu.ld_req = 1'b0;
    #2; chk1("fr_nodone", lu.ld_done, 1'b0); chk16("fr_data", lu.ld_data, 16'h2222);
    chk1("fr_stall0", lu.stall, 1'b0);
    tick();

    // Flush in REQ without grant drops the request next cycle.
    lu.ld_req = 1'b1; lu.ld_addr = 16'h0090; tick();
    lu.flush = 1'b1; #2; chk1("fq_rdreq1", lu.mem_rd_req, 1'b1); tick();
    lu.flush = 1'b0; lu.ld_req = 1'b0;
    #2; chk1("fq_rdreq0", lu.mem_rd_req, 1'b0); chk1("fq_stall", lu.stall, 1'b0); tick();

    // Flush beats ld_req in IDLE.
    lu.ld_req = 1'b1; lu.flush = 1'b1; lu.ld_addr = 16'h00A0;
    #2; chk1("fi_stall", lu.stall, 1'b1); tick(); lu.flush = 1'b0; lu.ld_req = 1'b0;
    #2; chk1("fi_rdreq", lu.mem_rd_req, 1'b0); chk1("fi_stall0", lu.stall, 1'b0); tick();

    // Reset asserted during WAIT.
    lu.ld_req = 1'b1; lu.ld_addr = 16'h0070; tick();
    lu.mem_gnt = 1'b1; tick(); lu.mem_gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk1("rw_rdreq", lu.mem_rd_req, 1'b0); chk16("rw_addr", lu.mem_addr, 16'h0000);
    chk1("rw_done", lu.ld_done, 1'b0); chk1("rw_err", lu.ld_err, 1'b0);
    chk16("rw_data", lu.ld_data, 16'h0000); chk1("rw_stall1", lu.stall, 1'b1);
    lu.ld_req = 1'b0;
    #1; chk1("rw_stall0", lu.stall, 1'b0);
    tick(); rst_n = 1'b1; tick();
    lu.mem_rvalid = 1'b1; lu.mem_rdata = 16'h4444; tick(); lu.mem_rvalid = 1'b0;
    #2; chk1("rw_late_done", lu.ld_done, 1'b0); chk16("rw_late_data", lu.ld_data, 16'h0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
